mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported CPU memory between instruction fetch (IF) and the EX/MEM data path (loads, stores, push/pop through the stack-pointer address).
- Each requester gets one transaction at a time. The arbiter drives stall signals that freeze the requesting pipeline stage until its access completes.
- Data accesses have priority. A starvation counter guarantees forward progress for fetch.
- A watchdog flags a hung memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending; range 1..15.
- TIMEOUT, 16, cycles a granted access may wait for mem_ready before forced completion; range 2..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- if_req  in  1  fetch request; held with if_addr stable until if_valid
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  branch redirect; cancels the in-flight fetch
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  fetch complete
- if_stall  out  1  if_req & ~if_valid
- dm_req  in  1  data request; held with its fields stable until dm_valid
- dm_we  in  1  1 = store/push, 0 = load/pop
- dm_addr  in  ADDR_W  data address (ALU result or SP)
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data
- dm_valid  out  1  data access complete
- dm_stall  out  1  dm_req & ~dm_valid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  access done this cycle
- bus_err  out  1  sticky timeout flag

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low. This is decided.
- Reset values:
  - State = IDLE.
  - mem_en, mem_we, if_valid, dm_valid and bus_err are 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata are 0.
  - Starvation and timeout counters are 0; the flush-pending flag is 0.
  - Reset mid-transaction abandons the access; no valid is ever issued for it.
- States: IDLE, GNT_IF, GNT_DM.
- IDLE arbitration (combinational, registered at the edge):
  - If dm_req and not (if_req and starve_cnt == STARVE_MAX), go to GNT_DM.
  - Otherwise, if if_req, go to GNT_IF.
  - Otherwise, stay in IDLE.
  - On the transition, latch addr, we and wdata into the mem_* registers.
  - IF latches we = 0 and wdata = 0.
- In a GNT state:
  - mem_en = 1; mem_* hold their latched values.
  - The timeout counter increments each cycle mem_ready = 0.
- Completion:
  - Completion occurs when mem_ready = 1, or when timeout_cnt == TIMEOUT-1 (forced completion).
  - Completion is the same cycle the grant's x_valid is asserted (combinational: granted & completion).
  - x_rdata = mem_rdata on a normal completion; 0 on a forced completion.
  - A forced completion also sets bus_err.
  - The next state is always IDLE, so at most one access occurs per two cycles.
  - Minimum latency: req in cycle 0, mem_en in cycle 1, valid in cycle 1 if mem_ready.
- mem_en is 0 in IDLE. mem_we is meaningful only while mem_en is 1.
- Starvation counter:
  - On a GNT_DM transition with if_req = 1, starve_cnt increments, saturating at STARVE_MAX.
  - On a GNT_IF transition, or a GNT_DM transition with if_req = 0, it clears.
- if_flush:
  - In GNT_IF, the flush sets the flush-pending flag. The memory transaction still runs to completion, but if_valid is suppressed at completion. The flag clears on completion.
  - if_flush in the same cycle as completion also suppresses if_valid.
  - In IDLE or GNT_DM, if_flush is ignored.
  - if_stall stays asserted while if_req is high and valid is suppressed.
- Requests:
  - A requester deasserts or changes its request only in the cycle after seeing its valid.
  - A request that drops mid-grant is not cancelled; the access completes and the valid is still pulsed.
- Both x_stall outputs are combinational from req and valid.
- bus_err clears only on reset.

Decomposition:
- mem_arb_pkg contains:
  - arb_state_t enum {IDLE, GNT_IF, GNT_DM}
  - the default parameter constants
- Single module. The timeout watchdog is small enough to stay inline; no sub-module.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_ready=1 on the first mem_en cycle with mem_rdata=0xDEADBEEF → mem_en for 1 cycle with mem_addr=0x100, mem_we=0; if_valid=1 and if_rdata=0xDEADBEEF in cycle 1; if_stall=1 in cycle 0.
- Simultaneous requests: if_req and dm_req (store 0x55 to 0x2000) in cycle 0, memory always ready → DM is granted first (mem_we=1, mem_wdata=0x55); IF is granted in cycle 3; dm_stall=0 from cycle 2.
- Starvation: dm_req continuously high, if_req high, STARVE_MAX=4 → exactly 4 DM grants, then 1 IF grant, then DM resumes.
- Wait states: mem_ready delayed 3 cycles → mem_en and mem_addr held stable for 4 cycles; valid only on the 4th; no bus_err.
- Flush: if_flush pulsed during a GNT_IF access with mem_ready delayed 2 cycles → if_valid never pulses; state returns to IDLE; a new if_addr=0x200 is fetched next.
- Timeout and reset: TIMEOUT=16 with mem_ready stuck at 0 → forced completion on the 16th grant cycle, dm_valid=1, dm_rdata=0, bus_err=1 (sticky); rst_n asserted mid-grant → all outputs 0 immediately.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the CPU memory-port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_STARVE_MAX = 4;
    localparam int unsigned DEF_TIMEOUT    = 16;

    // Counter widths sized for the legal parameter ranges (1..15, 2..255)
    localparam int unsigned STARVE_CNT_W  = 4;
    localparam int unsigned TIMEOUT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the data path.
// Data wins unless fetch has been passed over STARVE_MAX times in a row; a
// watchdog forces completion of a hung access and raises a sticky bus_err.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);

    arb_state_t                state, state_nxt;
    logic [STARVE_CNT_W-1:0]   starve_cnt, starve_nxt;
    logic [TIMEOUT_CNT_W-1:0]  tmo_cnt, tmo_nxt;
    logic                      flush_pend, flush_nxt;
    logic                      mem_en_nxt, mem_we_nxt, bus_err_nxt;
    logic [ADDR_W-1:0]         mem_addr_nxt;
    logic [DATA_W-1:0]         mem_wdata_nxt;
    logic                      granted, forced, complete, fetch_starved;

    // Completion: memory ready, or the watchdog expiring on this grant cycle
    assign granted       = (state != IDLE);
    assign forced        = granted & ~mem_ready & (tmo_cnt == TIMEOUT_CNT_W'(TIMEOUT - 1));
    assign complete      = granted & (mem_ready | forced);
    assign fetch_starved = if_req & (starve_cnt == STARVE_CNT_W'(STARVE_MAX));

    // Requester handshakes; a flushed fetch completes silently
    assign if_valid = (state == GNT_IF) & complete & ~flush_pend & ~if_flush;
    assign dm_valid = (state == GNT_DM) & complete;
    assign if_rdata = (if_valid & ~forced) ? mem_rdata : '0;
    assign dm_rdata = (dm_valid & ~forced) ? mem_rdata : '0;
    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

    // Next-state, arbitration, memory-command latch and counter updates
    always_comb begin
        state_nxt     = state;
        starve_nxt    = starve_cnt;
        tmo_nxt       = tmo_cnt;
        flush_nxt     = flush_pend;
        mem_en_nxt    = mem_en;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        bus_err_nxt   = bus_err;

        case (state)
            IDLE: begin
                if (dm_req && !fetch_starved) begin
                    state_nxt     = GNT_DM;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = dm_we;
                    mem_addr_nxt  = dm_addr;
                    mem_wdata_nxt = dm_wdata;
                    if (!if_req) begin
                        starve_nxt = '0;
                    end else if (starve_cnt != STARVE_CNT_W'(STARVE_MAX)) begin
                        starve_nxt = starve_cnt + STARVE_CNT_W'(1);
                    end
                end else if (if_req) begin
                    state_nxt     = GNT_IF;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = if_addr;
                    mem_wdata_nxt = '0;
                    starve_nxt    = '0;
                end
            end
            GNT_IF, GNT_DM: begin
                if (complete) begin
                    state_nxt  = IDLE;
                    mem_en_nxt = 1'b0;
                    tmo_nxt    = '0;
                    flush_nxt  = 1'b0;
                    if (forced) begin
                        bus_err_nxt = 1'b1;
                    end
                end else begin
                    tmo_nxt = tmo_cnt + TIMEOUT_CNT_W'(1);
                    if (state == GNT_IF && if_flush) begin
                        flush_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt  = IDLE;
                mem_en_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            flush_pend <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            tmo_cnt    <= tmo_nxt;
            flush_pend <= flush_nxt;
            mem_en     <= mem_en_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            bus_err    <= bus_err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus corner-case sequences,
// with per-requester scoreboards popped when the DUT pulses a valid.
module tb_mem_port_arbiter;

    localparam logic [31:0] RD_KEY = 32'hDEAD_BFEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, if_stall, dm_valid, dm_stall;
    logic        mem_en, mem_we, mem_ready, bus_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned en_run   = 0;
    int unsigned wait_n   = 0;
    int unsigned busy_cnt = 0;
    bit          stuck    = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned lat;   // 0 = not checked
        int unsigned en_n;  // 0 = not checked
        int unsigned t0;
    } exp_t;

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned wait_n;
        logic [31:0] exp_rdata;
        int unsigned exp_lat;
    } vec_t;

    exp_t if_q[$];
    exp_t dm_q[$];
    exp_t mon_e;
    logic order_q[$];
    vec_t vecs[7];

    mem_port_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .if_stall (if_stall),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_valid (dm_valid),
        .dm_stall (dm_stall),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data is a fixed function of the address; ready after wait_n stall cycles
    assign mem_rdata = mem_addr ^ RD_KEY;
    assign mem_ready = mem_en && !stuck && (busy_cnt == wait_n);
    always @(posedge clk) begin
        if (mem_en && !mem_ready) busy_cnt <= busy_cnt + 1;
        else                      busy_cnt <= 0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops the expectation of whichever requester completes
    always @(negedge clk) begin
        if (!mem_en) en_run = 0;
        else         en_run++;
        if (if_valid) begin
            order_q.push_back(1'b0);
            if (if_q.size() == 0) begin
                check("if_valid_unexpected", 64'(if_valid), 64'(0));
            end else begin
                mon_e = if_q.pop_front();
                check("if_rdata", 64'(if_rdata), 64'(mon_e.rdata));
                check("if_mem_addr", 64'(mem_addr), 64'(mon_e.addr));
                check("if_mem_we", 64'(mem_we), 64'(0));
                if (mon_e.lat != 0)  check("if_latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
                if (mon_e.en_n != 0) check("if_en_cycles", 64'(en_run), 64'(mon_e.en_n));
            end
        end
        if (dm_valid) begin
            order_q.push_back(1'b1);
            if (dm_q.size() == 0) begin
                check("dm_valid_unexpected", 64'(dm_valid), 64'(0));
            end else begin
                mon_e = dm_q.pop_front();
                check("dm_rdata", 64'(dm_rdata), 64'(mon_e.rdata));
                check("dm_mem_addr", 64'(mem_addr), 64'(mon_e.addr));
                check("dm_mem_we", 64'(mem_we), 64'(mon_e.we));
                if (mon_e.we)        check("dm_mem_wdata", 64'(mem_wdata), 64'(mon_e.wdata));
                if (mon_e.lat != 0)  check("dm_latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
                if (mon_e.en_n != 0) check("dm_en_cycles", 64'(en_run), 64'(mon_e.en_n));
            end
        end
    end

    // Fetch requester: call just after a rising edge; returns one cycle after its valid
    task automatic if_access(input logic [31:0] addr, input logic [31:0] rd,
                             input int unsigned lat, input int unsigned en_n);
        exp_t e;
        bit   got;
        got = 1'b0;
        e.addr = addr; e.we = 1'b0; e.wdata = '0; e.rdata = rd;
        e.lat = lat; e.en_n = en_n; e.t0 = cyc;
        if_q.push_back(e);
        if_addr = addr;
        if_req  = 1'b1;
        @(negedge clk);
        check("if_stall_c0", 64'(if_stall), 64'(1));
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (if_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("if_wait_expired", 64'(0), 64'(1));
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    // Data requester: same handshake as fetch
    task automatic dm_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rd, input int unsigned lat, input int unsigned en_n);
        exp_t e;
        bit   got;
        got = 1'b0;
        e.addr = addr; e.we = we; e.wdata = wdata; e.rdata = rd;
        e.lat = lat; e.en_n = en_n; e.t0 = cyc;
        dm_q.push_back(e);
        dm_we    = we;
        dm_addr  = addr;
        dm_wdata = wdata;
        dm_req   = 1'b1;
        @(negedge clk);
        check("dm_stall_c0", 64'(dm_stall), 64'(1));
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (dm_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("dm_wait_expired", 64'(0), 64'(1));
        @(posedge clk); #1;
        dm_req = 1'b0;
    endtask

    task automatic check_quiet(input string p);
        check({p, "_mem_en"},    64'(mem_en),    64'(0));
        check({p, "_mem_we"},    64'(mem_we),    64'(0));
        check({p, "_mem_addr"},  64'(mem_addr),  64'(0));
        check({p, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        check({p, "_if_valid"},  64'(if_valid),  64'(0));
        check({p, "_dm_valid"},  64'(dm_valid),  64'(0));
        check({p, "_if_rdata"},  64'(if_rdata),  64'(0));
        check({p, "_dm_rdata"},  64'(dm_rdata),  64'(0));
        check({p, "_bus_err"},   64'(bus_err),   64'(0));
        check({p, "_if_stall"},  64'(if_stall),  64'(0));
        check({p, "_dm_stall"},  64'(dm_stall),  64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got cycle %0d expected finish", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int unsigned t1;
        bit          got;
        logic        exp_order[7];

        //               is_dm we    addr          wdata         wait exp_rdata     lat
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         0,  32'hDEAD_BEEF, 1};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0,         0,  32'hDEAD_9FEB, 1};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_2000, 32'h55,        0,  32'hDEAD_9FEF, 1};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         3,  32'hDEAD_AFEF, 4};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1,  32'hDEAD_BFEF, 2};
        vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         2,  32'h2152_4013, 3};
        vecs[6] = '{1'b1, 1'b1, 32'h8000_0000, 32'hA5A5_A5A5, 14, 32'h5EAD_BFEF, 15};

        rst_n = 1'b0; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

        repeat (3) @(negedge clk);
        check_quiet("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_quiet("idle");
        @(posedge clk); #1;

        // Vector table: one isolated access per row
        for (int i = 0; i < 7; i++) begin
            wait_n = vecs[i].wait_n;
            if (vecs[i].is_dm)
                dm_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                          vecs[i].exp_lat, vecs[i].exp_lat);
            else
                if_access(vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_lat, vecs[i].exp_lat);
            check("vec_bus_err_clear", 64'(bus_err), 64'(0));
        end

        // Simultaneous requests: data first, fetch granted in cycle 3
        wait_n = 0;
        fork
            dm_access(1'b1, 32'h2000, 32'h55, 32'hDEAD_9FEF, 1, 1);
            if_access(32'h100, 32'hDEAD_BEEF, 3, 1);
            begin
                repeat (3) @(negedge clk);
                check("sim_dm_stall_c2", 64'(dm_stall), 64'(0));
                check("sim_if_stall_c2", 64'(if_stall), 64'(1));
                check("sim_mem_en_c2",   64'(mem_en),   64'(0));
            end
        join

        // Starvation: continuous data traffic lets fetch in after exactly 4 grants
        order_q.delete();
        fork
            begin
                for (int k = 0; k < 6; k++)
                    dm_access(1'b0, 32'h4000 + 32'(4 * k), 32'h0, (32'h4000 + 32'(4 * k)) ^ RD_KEY, 0, 0);
            end
            if_access(32'h300, 32'h300 ^ RD_KEY, 9, 1);
        join
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        check("starve_grant_count", 64'(order_q.size()), 64'(7));
        for (int k = 0; k < 7; k++) begin
            if (k < order_q.size()) check($sformatf("starve_order_%0d", k), 64'(order_q[k]), 64'(exp_order[k]));
        end

        // Flush during a wait-stated fetch, then refetch from the redirect target
        wait_n = 2;
        if_addr = 32'h180; if_req = 1'b1;
        @(posedge clk); #1;
        t1 = cyc;
        if_flush = 1'b1; if_addr = 32'h200;
        if_q.push_back('{32'h200, 1'b0, 32'h0, 32'h200 ^ RD_KEY, 0, 1, 0});
        @(negedge clk);
        check("flush_old_addr", 64'(mem_addr), 64'(32'h180));
        @(posedge clk); #1;
        if_flush = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (cyc - t1 == 2) begin
                check("flush_done_en",    64'(mem_en),   64'(1));
                check("flush_done_stall", 64'(if_stall), 64'(1));
            end
            if (cyc - t1 == 3) begin
                check("flush_idle_en",    64'(mem_en),   64'(0));
                check("flush_idle_stall", 64'(if_stall), 64'(1));
                wait_n = 0;
            end
            if (if_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("flush_refetch_seen", 64'(got), 64'(1));
        check("flush_refetch_cycle", 64'(cyc - t1), 64'(4));
        @(posedge clk); #1;
        if_req = 1'b0;

        // Flush coinciding with completion suppresses the valid
        if_addr = 32'h240; if_req = 1'b1;
        @(posedge clk); #1;
        if_flush = 1'b1;
        @(negedge clk);
        check("flush_last_valid", 64'(if_valid), 64'(0));
        check("flush_last_en",    64'(mem_en),   64'(1));
        check("flush_last_stall", 64'(if_stall), 64'(1));
        @(posedge clk); #1;
        if_flush = 1'b0; if_req = 1'b0;
        @(negedge clk);
        check("flush_last_idle", 64'(mem_en), 64'(0));
        @(posedge clk); #1;

        // Flush has no effect on a data grant
        fork
            dm_access(1'b0, 32'h2400, 32'h0, 32'h2400 ^ RD_KEY, 1, 1);
            begin
                @(posedge clk); #1; if_flush = 1'b1;
                @(posedge clk); #1; if_flush = 1'b0;
            end
        join

        // Watchdog: stuck memory forces completion on the 16th grant cycle
        stuck = 1'b1;
        dm_access(1'b0, 32'h3000, 32'h0, 32'h0, 16, 16);
        check("tmo_bus_err_set", 64'(bus_err), 64'(1));
        stuck = 1'b0;
        if_access(32'h100, 32'hDEAD_BEEF, 1, 1);
        check("tmo_bus_err_sticky", 64'(bus_err), 64'(1));

        // Reset in the middle of a stuck store abandons it
        stuck = 1'b1;
        dm_we = 1'b1; dm_addr = 32'h5000; dm_wdata = 32'h1234; dm_req = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_pre_en", 64'(mem_en), 64'(1));
        check("rstmid_pre_we", 64'(mem_we), 64'(1));
        #1;
        rst_n = 1'b0; dm_req = 1'b0;
        #1;
        check_quiet("rstmid");
        @(negedge clk);
        rst_n = 1'b1; stuck = 1'b0;
        repeat (5) @(negedge clk);
        check("rstmid_after_en", 64'(mem_en), 64'(0));
        check("rstmid_after_err", 64'(bus_err), 64'(0));

        check("if_queue_drained", 64'(if_q.size()), 64'(0));
        check("dm_queue_drained", 64'(dm_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
